// File: rtl/ir_sir_tx.sv
// IrDA SIR transmitter: UART-framed bytes sent as 3/16-bit-period IR pulses for each 0 bit,
// followed by a receiver-blanking guard interval.
module ir_sir_tx #(
  parameter int CLK_HZ     = 74_250_000,
  parameter int BAUD       = 115_200,
  parameter int GUARD_CLKS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  input  logic       rx_listen,
  output logic       ir_tx,
  output logic       ir_rx_disable
);

  localparam int BIT_CLKS   = CLK_HZ / BAUD;
  localparam int PULSE_CLKS = (3 * BIT_CLKS) / 16;
  localparam int BW         = $clog2(BIT_CLKS);
  localparam int GW         = (GUARD_CLKS > 1) ? $clog2(GUARD_CLKS) : 1;

  localparam logic [BW-1:0] BIT_LAST   = BW'(BIT_CLKS - 1);
  localparam logic [BW-1:0] PULSE_END  = BW'(PULSE_CLKS);
  localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CLKS > 0) ? GUARD_CLKS - 1 : 0);

  generate
    if (BIT_CLKS < 16) begin : g_bit_clks_check
      $error("ir_sir_tx: CLK_HZ/BAUD must be at least 16");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GUARD} state_t;

  state_t          r_state,     w_state_nxt;
  logic [BW-1:0]   r_bit_cnt,   w_bit_cnt_nxt;
  logic [2:0]      r_bit_idx,   w_bit_idx_nxt;
  logic [GW-1:0]   r_guard_cnt, w_guard_cnt_nxt;
  logic [7:0]      r_shift,     w_shift_nxt;
  logic            r_rx_dis;
  logic            w_bit_end;
  logic            w_busy;
  logic            w_zero_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_bit_idx   <= '0;
      r_guard_cnt <= '0;
      r_shift     <= '0;
      r_rx_dis    <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_guard_cnt <= w_guard_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_dis    <= w_busy || !rx_listen;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_guard_cnt_nxt = r_guard_cnt;
    w_shift_nxt     = r_shift;
    w_bit_end       = (r_bit_cnt == BIT_LAST);

    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_state_nxt   = S_START;
          w_shift_nxt   = tx_data;
          w_bit_cnt_nxt = '0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_bit_cnt_nxt = '0;
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_bit_cnt_nxt   = '0;
          w_guard_cnt_nxt = '0;
          w_state_nxt     = (GUARD_CLKS == 0) ? S_IDLE : S_GUARD;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_GUARD: begin
        if (r_guard_cnt == GUARD_LAST) begin
          w_state_nxt     = S_IDLE;
          w_guard_cnt_nxt = '0;
        end else begin
          w_guard_cnt_nxt = r_guard_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs gated by reset so they read idle during the reset cycle itself.
  assign w_busy        = (r_state != S_IDLE);
  assign w_zero_bit    = (r_state == S_START) || ((r_state == S_DATA) && !r_shift[0]);
  assign tx_busy       = w_busy && !reset;
  assign tx_ready      = (r_state == S_IDLE) && !reset;
  assign ir_tx         = !reset && w_zero_bit && (r_bit_cnt < PULSE_END);
  assign ir_rx_disable = r_rx_dis;

endmodule

// File: tb/tb_ir_sir_tx.sv
// Directed bench for ir_sir_tx at BIT_CLKS = 16, PULSE_CLKS = 3, GUARD_CLKS = 8.
module tb_ir_sir_tx;

  localparam int NCAP = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       rx_listen;
  logic       ir_tx;
  logic       ir_rx_disable;

  int checks = 0;
  int errors = 0;

  logic cap_tx  [0:NCAP-1];
  logic cap_rd  [0:NCAP-1];
  logic cap_dis [0:NCAP-1];

  ir_sir_tx #(
    .CLK_HZ    (1_600_000),
    .BAUD      (100_000),
    .GUARD_CLKS(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .rx_listen    (rx_listen),
    .ir_tx        (ir_tx),
    .ir_rx_disable(ir_rx_disable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Index k holds the cycle k+1 after the acceptance cycle.
  task automatic capture();
    for (int k = 0; k < NCAP; k++) begin
      cap_tx[k]  = ir_tx;
      cap_rd[k]  = tx_ready;
      cap_dis[k] = ir_rx_disable;
      @(negedge clk);
    end
  endtask

  task automatic send_capture(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    check("ready_at_send", int'(tx_ready), 1);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    capture();
  endtask

  task automatic check_frame(input string tag, input logic [9:0] mask_exp, input int highs_exp);
    logic [9:0] mask;
    int highs, wave_err, ready_at;
    logic expv;
    mask = '0; highs = 0; wave_err = 0; ready_at = -1;
    for (int k = 0; k < NCAP; k++) begin
      if (cap_tx[k] === 1'b1) begin
        highs++;
        if (k < 160) mask[k/16] = 1'b1;
      end
      expv = (k < 160) && mask_exp[k/16] && ((k % 16) < 3);
      if (cap_tx[k] !== expv) wave_err++;
      if (ready_at < 0 && cap_rd[k] === 1'b1) ready_at = k;
    end
    check({tag, "_first_pulse"}, int'(cap_tx[0]), 1);
    check({tag, "_slot_mask"}, int'(mask), int'(mask_exp));
    check({tag, "_high_cycles"}, highs, highs_exp);
    check({tag, "_wave_errs"}, wave_err, 0);
    check({tag, "_ready_return"}, ready_at, 168);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int gap, cnt;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_listen = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(tx_ready), 0);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_ir_tx", int'(ir_tx), 0);
    check("rst_rx_dis", int'(ir_rx_disable), 1);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(tx_ready), 1);
    check("post_rst_busy", int'(tx_busy), 0);
    check("idle_rx_dis_listen", int'(ir_rx_disable), 0);

    // 0x00: pulses in slots 0..8
    send_capture(8'h00);
    check_frame("b00", 10'h1FF, 27);

    // 0xFF: start bit only; also receiver blanking window with rx_listen = 1
    send_capture(8'hFF);
    check_frame("bFF", 10'h001, 3);
    cnt = 0;
    for (int k = 1; k <= 168; k++) if (cap_dis[k] === 1'b1) cnt++;
    check("listen_dis_window", cnt, 168);
    check("listen_dis_after", int'(cap_dis[169]), 0);
    check("listen_dis_busy_mid", int'(cap_rd[100]), 0);

    // 0xA5: zeros at data bits 1,3,4,6 -> slots 0,2,4,5,7
    send_capture(8'hA5);
    check_frame("bA5", 10'h0B5, 15);

    // tx_valid held with two bytes: second acceptance 169 cycles later
    @(negedge clk);
    tx_data = 8'h3C; tx_valid = 1'b1;
    check("b2b_first_ready", int'(tx_ready), 1);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) tx_data = 8'hC3;
    end while (tx_ready !== 1'b1 && gap < 400);
    check("b2b_gap", gap, 169);
    @(negedge clk);
    tx_valid = 1'b0;
    capture();
    // 0xC3: zeros at data bits 2..5 -> slots 0,3,4,5,6
    check_frame("bC3", 10'h079, 15);

    // rx_listen = 0: receiver always disabled, framing unchanged
    rx_listen = 1'b0;
    repeat (2) @(negedge clk);
    check("nolisten_idle_dis", int'(ir_rx_disable), 1);
    send_capture(8'h00);
    check_frame("nl00", 10'h1FF, 27);
    cnt = 0;
    for (int k = 0; k < NCAP; k++) if (cap_dis[k] === 1'b1) cnt++;
    check("nolisten_dis_all", cnt, NCAP);
    rx_listen = 1'b1;
    repeat (2) @(negedge clk);
    check("relisten_idle_dis", int'(ir_rx_disable), 0);

    // Reset at cycle 50 of a 0x00 frame (slot 3, offset 2: pulse high)
    @(negedge clk);
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (50) @(negedge clk);
    check("pre_rst_ir_tx", int'(ir_tx), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ir_tx", int'(ir_tx), 0);
    check("mid_rst_rx_dis", int'(ir_rx_disable), 1);
    check("mid_rst_ready", int'(tx_ready), 0);
    check("mid_rst_busy", int'(tx_busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", int'(tx_ready), 1);
    check("abort_busy", int'(tx_busy), 0);
    cnt = 0;
    for (int k = 0; k < NCAP; k++) begin
      if (ir_tx === 1'b1) cnt++;
      @(negedge clk);
    end
    check("abort_no_pulses", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_sir_tx.md
IR_SIR_TX -- requirements
Module: ir_sir_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 74_250_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, IR bit rate in bits/s.
REQ-003 SHALL have parameter GUARD_CLKS, default 256, receiver-blanking cycles after each frame; 0 allowed.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tx_data  input  8  byte to transmit, sampled on acceptance.
REQ-007 SHALL have port tx_valid  input  1  tx_data valid.
REQ-008 SHALL have port tx_ready  output  1  block can accept a byte.
REQ-009 SHALL have port tx_busy  output  1  frame or guard in progress.
REQ-010 SHALL have port rx_listen  input  1  user wants the IR receiver powered.
REQ-011 SHALL have port ir_tx  output  1  IR LED drive, active high.
REQ-012 SHALL have port ir_rx_disable  output  1  IR receiver disable, active high.

Function
REQ-013 SHALL derive BIT_CLKS = CLK_HZ/BAUD (integer truncation) and PULSE_CLKS = (3*BIT_CLKS)/16.
REQ-014 SHALL fail elaboration if BIT_CLKS < 16.
REQ-015 SHALL size all counters with $clog2 of their maximum count; no counter wraps during normal operation.
REQ-016 SHALL implement states IDLE, START, DATA, STOP, GUARD.
REQ-017 SHALL assert tx_ready only in IDLE; a byte is accepted on a cycle where tx_valid && tx_ready.
REQ-018 SHALL, on acceptance, latch tx_data and enter START on the next cycle; tx_data/tx_valid ignored outside IDLE.
REQ-019 SHALL hold START, each DATA bit and STOP for exactly BIT_CLKS cycles each; frame = 10*BIT_CLKS cycles.
REQ-020 SHALL send start bit 0, 8 data bits LSB first, stop bit 1.
REQ-021 SHALL encode a 0 bit as ir_tx high for the first PULSE_CLKS cycles of the bit period, then low; a 1 bit as ir_tx low for the whole period.
REQ-022 SHALL therefore raise ir_tx the cycle after acceptance (1-cycle latency).
REQ-023 SHALL go STOP -> GUARD for GUARD_CLKS cycles, then IDLE; if GUARD_CLKS = 0, STOP -> IDLE directly.
REQ-024 SHALL give an acceptance-to-next-acceptance minimum of 10*BIT_CLKS + GUARD_CLKS + 1 cycles.
REQ-025 SHALL drive tx_busy high in every state except IDLE.
REQ-026 SHALL drive ir_rx_disable = tx_busy || !rx_listen, registered (one cycle after the state change).
REQ-027 SHALL keep ir_tx low in IDLE, STOP and GUARD.
REQ-028 SHALL let rx_listen changes affect ir_rx_disable only; framing is unaffected.

Reset
REQ-029 SHALL, while reset is high, force state IDLE, ir_tx = 0, ir_rx_disable = 1, tx_busy = 0, tx_ready = 0, counters = 0.
REQ-030 SHALL abort any frame in progress on reset with no further ir_tx pulses; tx_ready rises the first cycle after reset deasserts.

Verification (CLK_HZ = 1_600_000, BAUD = 100_000 -> BIT_CLKS = 16, PULSE_CLKS = 3; GUARD_CLKS = 8)
REQ-031 SHALL verify: send 0x00 -> 9 ir_tx pulses, 3 cycles high each, rising edges 16 cycles apart, first 1 cycle after acceptance; frame 160 cycles.
REQ-032 SHALL verify: send 0xFF -> single 3-cycle pulse (start bit); tx_ready returns after 160 + 8 cycles.
REQ-033 SHALL verify: send 0xA5 -> pulses in bit slots 0 (start), 2, 4, 5, 7 (data bits 1, 3, 4, 6); none in slots 1, 3, 6, 8, 9.
REQ-034 SHALL verify: tx_valid held high with two bytes queued -> second acceptance exactly 169 cycles after the first; tx_ready low throughout.
REQ-035 SHALL verify: rx_listen = 1 -> ir_rx_disable low in IDLE, high from 1 cycle after acceptance to 1 cycle after GUARD ends; rx_listen = 0 -> always high.
REQ-036 SHALL verify: reset asserted at cycle 50 of a 0x00 frame -> ir_tx low, ir_rx_disable high next cycle, no pulses afterwards, tx_ready high 1 cycle after reset deasserts.
